// File: rtl/bit_frame_if.sv
// Serial-in / word-out handshake bundle between the bit source, the collector
// and the downstream word consumer.
interface bit_frame_if #(
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(WIDTH + 1)
);
    logic             bit_in;
    logic             bit_valid;
    logic             sync_clear;
    logic [WIDTH-1:0] word_out;
    logic [CW-1:0]    ones_out;
    logic             word_valid;
    logic             word_ready;
    logic             overflow;
    logic [7:0]       drop_count;
    logic             busy;

    // Stimulus/consumer side.
    modport master (
        output bit_in, bit_valid, sync_clear, word_ready,
        input  word_out, ones_out, word_valid, overflow, drop_count, busy
    );

    // Collector side.
    modport slave (
        input  bit_in, bit_valid, sync_clear, word_ready,
        output word_out, ones_out, word_valid, overflow, drop_count, busy
    );
endinterface

// File: rtl/bit_frame_collector.sv
// Assembles MSB-first words from a serial bit stream, counts their ones and
// queues them in a show-ahead FIFO. Words arriving while the FIFO is full are
// dropped and counted.
//
// state   | meaning
// IDLE    | no partial word held, bit counter at 0
// COLLECT | 1..WIDTH-1 bits of the current word held
module bit_frame_collector #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = $clog2(WIDTH + 1)
) (
    input logic        clk,
    input logic        reset,
    bit_frame_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_q, shift_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic [CW-1:0]    ones_q, ones_nxt;
    logic             push;
    logic [WIDTH-1:0] push_word;
    logic [CW-1:0]    push_ones;

    logic [WIDTH-1:0] word_mem [FIFO_DEPTH];
    logic [CW-1:0]    ones_mem [FIFO_DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      occ;
    logic             empty, full, pop, do_push, drop;
    logic             overflow_q;
    logic [7:0]       drop_q;

    // Collector state, shift register, bit counter and ones accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            ones_q  <= '0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            cnt_q   <= cnt_nxt;
            ones_q  <= ones_nxt;
        end
    end

    // Next-state: accept bits, complete the word on the WIDTH-th bit.
    // A sync_clear overrides everything, including a completing bit.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        cnt_nxt   = cnt_q;
        ones_nxt  = ones_q;
        push      = 1'b0;
        push_word = '0;
        push_ones = '0;
        if (bus.sync_clear) begin
            state_nxt = IDLE;
            shift_nxt = '0;
            cnt_nxt   = '0;
            ones_nxt  = '0;
        end else if (bus.bit_valid) begin
            push_word = {shift_q[WIDTH-2:0], bus.bit_in};
            push_ones = ones_q + CW'(bus.bit_in);
            if (cnt_q == CW'(WIDTH - 1)) begin
                push      = 1'b1;
                state_nxt = IDLE;
                shift_nxt = '0;
                cnt_nxt   = '0;
                ones_nxt  = '0;
            end else begin
                state_nxt = COLLECT;
                shift_nxt = push_word;
                cnt_nxt   = cnt_q + CW'(1);
                ones_nxt  = push_ones;
            end
        end
    end

    assign empty   = (occ == '0);
    assign full    = (occ == (AW + 1)'(FIFO_DEPTH));
    assign pop     = !empty && bus.word_ready;
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    // FIFO storage, pointers and occupancy; pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                word_mem[i] <= '0;
                ones_mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                word_mem[wr_ptr] <= push_word;
                ones_mem[wr_ptr] <= push_ones;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !pop) begin
                occ <= occ + (AW + 1)'(1);
            end else if (pop && !do_push) begin
                occ <= occ - (AW + 1)'(1);
            end
        end
    end

    // Sticky overflow flag and saturating drop counter, cleared by sync_clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (bus.sync_clear) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign bus.word_valid = !empty;
    assign bus.word_out   = empty ? '0 : word_mem[rd_ptr];
    assign bus.ones_out   = empty ? '0 : ones_mem[rd_ptr];
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_q;
    assign bus.busy       = (state == COLLECT);
endmodule

// File: tb/tb_bit_frame_collector.sv
// Directed bench for bit_frame_collector: a vector table for the basic and
// gapped word cases, then hand-written sequences for backpressure, overflow,
// sync_clear, drop saturation and asynchronous reset.
module tb_bit_frame_collector;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    bit_frame_if #(.WIDTH(8)) bus ();

    bit_frame_collector #(.WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       b;
        logic       v;
        logic       sc;
        logic       rdy;
        logic       exp_valid;
        logic [7:0] exp_word;
        logic [3:0] exp_ones;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_row(input logic b, input logic v, input logic rdy, input logic ev,
                           input logic [7:0] ew, input logic [3:0] eo, input logic eb);
        vec_t r;
        r.b = b; r.v = v; r.sc = 1'b0; r.rdy = rdy;
        r.exp_valid = ev; r.exp_word = ew; r.exp_ones = eo; r.exp_busy = eb;
        vecs.push_back(r);
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            bus.bit_in    = w[i];
            bus.bit_valid = 1'b1;
            step();
        end
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [7:0] w);
        check({name, "_valid"}, 32'(bus.word_valid), 32'd1);
        check({name, "_word"}, 32'(bus.word_out), 32'(w));
        check({name, "_ones"}, 32'(bus.ones_out), 32'($countones(w)));
        bus.word_ready = 1'b1;
        step();
        bus.word_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.sync_clear = 1'b1;
        step();
        bus.sync_clear = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] gap;

        bus.bit_in = 1'b0;
        bus.bit_valid = 1'b0;
        bus.sync_clear = 1'b0;
        bus.word_ready = 1'b0;

        // Vector table: basic word 0xB2 then gapped word 0x20.
        pat = 8'hB2;
        for (int i = 0; i < 8; i++) begin
            if (i < 7) add_row(pat[7-i], 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
            else       add_row(pat[7-i], 1'b1, 1'b1, 1'b1, 8'hB2, 4'd4, 1'b0);
        end
        add_row(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        gap = 8'h20;
        for (int i = 0; i < 8; i++) begin
            if (i < 7) begin
                add_row(gap[7-i], 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
                add_row(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
            end else begin
                add_row(gap[7-i], 1'b1, 1'b1, 1'b1, 8'h20, 4'd1, 1'b0);
                add_row(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
            end
        end

        #2;
        check("rst_valid", 32'(bus.word_valid), 32'd0);
        check("rst_word", 32'(bus.word_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_drop", 32'(bus.drop_count), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        step();
        reset = 1'b0;
        step();

        foreach (vecs[k]) begin
            bus.bit_in     = vecs[k].b;
            bus.bit_valid  = vecs[k].v;
            bus.sync_clear = vecs[k].sc;
            bus.word_ready = vecs[k].rdy;
            step();
            check($sformatf("vec%0d_valid", k), 32'(bus.word_valid), 32'(vecs[k].exp_valid));
            check($sformatf("vec%0d_word", k), 32'(bus.word_out), 32'(vecs[k].exp_word));
            check($sformatf("vec%0d_ones", k), 32'(bus.ones_out), 32'(vecs[k].exp_ones));
            check($sformatf("vec%0d_busy", k), 32'(bus.busy), 32'(vecs[k].exp_busy));
        end
        bus.bit_valid = 1'b0;
        bus.word_ready = 1'b0;

        // Backpressure: six words into a four-deep FIFO.
        for (int w = 1; w <= 6; w++) send_word(8'(w));
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        check("ovf_drop", 32'(bus.drop_count), 32'd2);
        step(); step();
        check("hold_head", 32'(bus.word_out), 32'h01);
        for (int w = 1; w <= 4; w++) pop_expect($sformatf("ovf_pop%0d", w), 8'(w));
        check("ovf_empty", 32'(bus.word_valid), 32'd0);

        // Full FIFO with pop on the same edge as the completing bit.
        pulse_clear();
        send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
        for (int i = 7; i >= 0; i--) begin
            bus.bit_in     = pat[i];
            bus.bit_valid  = 1'b1;
            bus.word_ready = (i == 0);
            step();
        end
        bus.bit_valid = 1'b0;
        bus.word_ready = 1'b0;
        check("simul_drop", 32'(bus.drop_count), 32'd0);
        check("simul_ovf", 32'(bus.overflow), 32'd0);
        pop_expect("simul_pop22", 8'h22);
        pop_expect("simul_pop33", 8'h33);
        pop_expect("simul_pop44", 8'h44);
        pop_expect("simul_popB2", 8'hB2);
        check("simul_empty", 32'(bus.word_valid), 32'd0);

        // sync_clear mid-word with overflow set and FIFO contents kept.
        for (int w = 0; w < 5; w++) send_word(8'h61 + 8'(w));
        check("sc_pre_ovf", 32'(bus.overflow), 32'd1);
        check("sc_pre_drop", 32'(bus.drop_count), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.bit_in = 1'b1; bus.bit_valid = 1'b1; step();
        end
        check("sc_pre_busy", 32'(bus.busy), 32'd1);
        bus.sync_clear = 1'b1;
        step();
        bus.sync_clear = 1'b0;
        bus.bit_valid = 1'b0;
        check("sc_busy", 32'(bus.busy), 32'd0);
        check("sc_ovf", 32'(bus.overflow), 32'd0);
        check("sc_drop", 32'(bus.drop_count), 32'd0);
        for (int w = 0; w < 4; w++) pop_expect($sformatf("sc_pop%0d", w), 8'h61 + 8'(w));
        check("sc_empty", 32'(bus.word_valid), 32'd0);
        send_word(8'hFF);
        check("ff_word", 32'(bus.word_out), 32'hFF);
        check("ff_ones", 32'(bus.ones_out), 32'd8);
        bus.word_ready = 1'b1;
        step();
        bus.word_ready = 1'b0;
        check("ff_popped", 32'(bus.word_valid), 32'd0);
        for (int i = 0; i < 7; i++) begin
            bus.bit_in = 1'b1; bus.bit_valid = 1'b1; step();
        end
        bus.sync_clear = 1'b1;
        step();
        bus.sync_clear = 1'b0;
        bus.bit_valid = 1'b0;
        step();
        check("sc_last_nopush", 32'(bus.word_valid), 32'd0);
        check("sc_last_busy", 32'(bus.busy), 32'd0);

        // Drop counter saturation, then asynchronous reset mid-word.
        for (int w = 0; w < 260; w++) send_word(8'(w));
        check("sat_drop", 32'(bus.drop_count), 32'd255);
        check("sat_head", 32'(bus.word_out), 32'h00);
        check("sat_valid", 32'(bus.word_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            bus.bit_in = 1'b1; bus.bit_valid = 1'b1; step();
        end
        bus.bit_valid = 1'b0;
        check("ar_pre_busy", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", 32'(bus.word_valid), 32'd0);
        check("ar_busy", 32'(bus.busy), 32'd0);
        check("ar_ovf", 32'(bus.overflow), 32'd0);
        check("ar_drop", 32'(bus.drop_count), 32'd0);
        check("ar_word", 32'(bus.word_out), 32'd0);
        step();
        reset = 1'b0;
        step();
        bus.word_ready = 1'b1;
        send_word(8'hA5);
        check("ar_next_valid", 32'(bus.word_valid), 32'd1);
        check("ar_next_word", 32'(bus.word_out), 32'hA5);
        check("ar_next_ones", 32'(bus.ones_out), 32'd4);
        step();
        check("ar_next_only", 32'(bus.word_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
